branch_ctrl_seq: RTL and testbench

Sequences branch and jump resolution for the RISC-V core. It accepts one control-transfer op at a time from decode over a valid/ready handshake. It evaluates the branch condition from func_3 and the operands, computes the target, and on a taken result issues a one-cycle PC redirect plus a multi-cycle pipeline flush. It sits between decode/register-read and the PC/fetch stage, and owns the branch-decision datapath.

---
 rtl/branch_ctrl_seq_if.sv | 38 +++
 rtl/branch_ctrl_seq.sv | 189 ++++++++++++++++++
 tb/tb_branch_ctrl_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_seq_if.sv
// Decode-side request and fetch-side resolution signals of the branch controller.
interface branch_ctrl_seq_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             br_valid;
    logic             br_ready;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic [2:0]       func_3;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             link_valid;
    logic [XLEN-1:0]  link_data;
    logic             flush;
    logic             done;
    logic             misalign_exc;
    logic             illegal_exc;
    logic [CNT_W-1:0] taken_count;
    logic [CNT_W-1:0] resolved_count;

    modport master (
        output br_valid, is_branch, is_jal, is_jalr, func_3, rs1_data, rs2_data, pc, imm,
        input  br_ready, redirect_valid, redirect_pc, link_valid, link_data, flush, done,
               misalign_exc, illegal_exc, taken_count, resolved_count
    );

    modport slave (
        input  br_valid, is_branch, is_jal, is_jalr, func_3, rs1_data, rs2_data, pc, imm,
        output br_ready, redirect_valid, redirect_pc, link_valid, link_data, flush, done,
               misalign_exc, illegal_exc, taken_count, resolved_count
    );
endinterface

// File: rtl/branch_ctrl_seq.sv
// Branch/jump resolution sequencer: evaluates one control-transfer op at a time,
// issues the PC redirect and holds the front-end flush.
module branch_ctrl_seq #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input logic              clk,
    input logic              rst_n,
    branch_ctrl_seq_if.slave bus
);
    localparam int              FC_W       = 4;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_REDIRECT, S_FLUSH} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_BRANCH, OP_JAL, OP_JALR} op_t;

    state_t           state_q, state_d;
    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic             done_q, done_d;
    logic             redir_q, redir_d;
    logic             link_q, link_d;
    logic             flush_q, flush_d;
    logic             mis_q, mis_d;
    logic             ill_q, ill_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0]  link_data_q, link_data_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] resolved_cnt_q, resolved_cnt_d;

    op_t              op_q, op_in;
    logic [2:0]       func3_q;
    logic [XLEN-1:0]  rs1_q, rs2_q, pc_q, imm_q;
    logic signed [XLEN-1:0] rs1_s, rs2_s;

    logic             accept, cond, taken, illegal;
    logic [XLEN-1:0]  target;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign accept = bus.br_valid && (state_q == S_IDLE);
    assign rs1_s  = rs1_q;
    assign rs2_s  = rs2_q;

    always_comb begin
        op_in = OP_NONE;
        if (bus.is_jalr)        op_in = OP_JALR;
        else if (bus.is_jal)    op_in = OP_JAL;
        else if (bus.is_branch) op_in = OP_BRANCH;
    end

    // Operand capture is pure datapath and is only consumed after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= op_in;
            func3_q <= bus.func_3;
            rs1_q   <= bus.rs1_data;
            rs2_q   <= bus.rs2_data;
            pc_q    <= bus.pc;
            imm_q   <= bus.imm;
        end
    end

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (func3_q)
            3'b000:  cond = (rs1_q == rs2_q);
            3'b001:  cond = (rs1_q != rs2_q);
            3'b100:  cond = (rs1_s <  rs2_s);
            3'b101:  cond = (rs1_s >= rs2_s);
            3'b110:  cond = (rs1_q <  rs2_q);
            3'b111:  cond = (rs1_q >= rs2_q);
            default: illegal = (op_q == OP_BRANCH);
        endcase
        case (op_q)
            OP_JAL, OP_JALR: taken = 1'b1;
            OP_BRANCH:       taken = cond;
            default:         taken = 1'b0;
        endcase
        if (op_q == OP_JALR) target = (rs1_q + imm_q) & {{(XLEN-1){1'b1}}, 1'b0};
        else                 target = pc_q + imm_q;
    end

    always_comb begin
        state_d        = state_q;
        fcnt_d         = fcnt_q;
        done_d         = 1'b0;
        redir_d        = 1'b0;
        link_d         = 1'b0;
        flush_d        = 1'b0;
        mis_d          = 1'b0;
        ill_d          = 1'b0;
        redirect_pc_d  = redirect_pc_q;
        link_data_d    = link_data_q;
        taken_cnt_d    = taken_cnt_q;
        resolved_cnt_d = resolved_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d        = S_EVAL;
                    resolved_cnt_d = sat_inc(resolved_cnt_q);
                end
            end
            S_EVAL: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (illegal) begin
                    ill_d = 1'b1;
                end else if (taken && target[1]) begin
                    mis_d = 1'b1;
                end else if (taken) begin
                    // Strobes are registered, so they rise together with the REDIRECT state.
                    state_d       = S_REDIRECT;
                    redir_d       = 1'b1;
                    flush_d       = 1'b1;
                    redirect_pc_d = target;
                    taken_cnt_d   = sat_inc(taken_cnt_q);
                    if (op_q == OP_JAL || op_q == OP_JALR) begin
                        link_d      = 1'b1;
                        link_data_d = pc_q + XLEN'(4);
                    end
                end
            end
            S_REDIRECT: begin
                fcnt_d = FLUSH_LOAD;
                if (FLUSH_LOAD == '0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FLUSH;
                    flush_d = 1'b1;
                end
            end
            S_FLUSH: begin
                fcnt_d = fcnt_q - FC_W'(1);
                if (fcnt_q == FC_W'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    flush_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            fcnt_q         <= '0;
            done_q         <= 1'b0;
            redir_q        <= 1'b0;
            link_q         <= 1'b0;
            flush_q        <= 1'b0;
            mis_q          <= 1'b0;
            ill_q          <= 1'b0;
            redirect_pc_q  <= '0;
            link_data_q    <= '0;
            taken_cnt_q    <= '0;
            resolved_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            fcnt_q         <= fcnt_d;
            done_q         <= done_d;
            redir_q        <= redir_d;
            link_q         <= link_d;
            flush_q        <= flush_d;
            mis_q          <= mis_d;
            ill_q          <= ill_d;
            redirect_pc_q  <= redirect_pc_d;
            link_data_q    <= link_data_d;
            taken_cnt_q    <= taken_cnt_d;
            resolved_cnt_q <= resolved_cnt_d;
        end
    end

    assign bus.br_ready       = (state_q == S_IDLE);
    assign bus.redirect_valid = redir_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.link_valid     = link_q;
    assign bus.link_data      = link_data_q;
    assign bus.flush          = flush_q;
    assign bus.done           = done_q;
    assign bus.misalign_exc   = mis_q;
    assign bus.illegal_exc    = ill_q;
    assign bus.taken_count    = taken_cnt_q;
    assign bus.resolved_count = resolved_cnt_q;
endmodule

// File: tb/tb_branch_ctrl_seq.sv
// Bench for branch_ctrl_seq: directed vector table, hold/reset sequences, random ops vs a reference model.
module tb_branch_ctrl_seq;
    localparam int XLEN = 32;
    localparam int FC   = 2;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;
    localparam int NTBL = 17;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_ctrl_seq_if #(.XLEN(XLEN), .CNT_W(CW)) bif ();

    branch_ctrl_seq #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    typedef struct {
        logic        br, jal, jalr;
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, pc, imm;
        logic        red;
        logic [31:0] rpc;
        logic        lnk;
        logic [31:0] ldata;
        logic        mis, ill;
    } vec_t;

    typedef struct {
        int          done_k, n_done, redir_k, n_red, n_link, n_mis, n_ill, n_flush, ready_k;
        logic [31:0] rpc, ldata;
    } obs_t;

    int   total = 0;
    int   bad   = 0;
    int   exp_res = 0;
    int   exp_tk  = 0;
    vec_t tbl [NTBL];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                                input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                                input logic [31:0] imm, input logic red, input logic [31:0] rpc,
                                input logic lnk, input logic [31:0] ldata, input logic mis, input logic ill);
        vec_t v;
        v.br = br; v.jal = jal; v.jalr = jalr; v.f3 = f3;
        v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm;
        v.red = red; v.rpc = rpc; v.lnk = lnk; v.ldata = ldata; v.mis = mis; v.ill = ill;
        return v;
    endfunction

    // Reference behaviour straight from the ISA rules for control transfers.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        logic [31:0] tgt;
        int signed   a, b;
        bit          tk, link, ill;
        r = v; tk = 0; link = 0; ill = 0; tgt = 32'h0;
        a = v.rs1; b = v.rs2;
        r.red = 0; r.rpc = 0; r.lnk = 0; r.ldata = 0; r.mis = 0; r.ill = 0;
        if (v.jalr) begin
            tgt = (v.rs1 + v.imm) & 32'hFFFF_FFFE; tk = 1; link = 1;
        end else if (v.jal) begin
            tgt = v.pc + v.imm; tk = 1; link = 1;
        end else if (v.br) begin
            tgt = v.pc + v.imm;
            case (v.f3)
                3'd0:    tk = (v.rs1 == v.rs2);
                3'd1:    tk = (v.rs1 != v.rs2);
                3'd4:    tk = (a < b);
                3'd5:    tk = (a >= b);
                3'd6:    tk = (v.rs1 < v.rs2);
                3'd7:    tk = (v.rs1 >= v.rs2);
                default: ill = 1;
            endcase
        end
        if (ill)               r.ill = 1;
        else if (tk && tgt[1]) r.mis = 1;
        else if (tk) begin
            r.red = 1; r.rpc = tgt; r.lnk = link; r.ldata = v.pc + 32'd4;
        end
        return r;
    endfunction

    task automatic drive(input vec_t v);
        bif.br_valid  = 1'b1;
        bif.is_branch = v.br;
        bif.is_jal    = v.jal;
        bif.is_jalr   = v.jalr;
        bif.func_3    = v.f3;
        bif.rs1_data  = v.rs1;
        bif.rs2_data  = v.rs2;
        bif.pc        = v.pc;
        bif.imm       = v.imm;
    endtask

    task automatic observe(output obs_t o);
        o = '{default: 0};
        o.done_k = -1; o.redir_k = -1; o.ready_k = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bif.done)           begin o.n_done++; o.done_k = k; end
            if (bif.redirect_valid) begin o.n_red++; o.redir_k = k; o.rpc = bif.redirect_pc; end
            if (bif.link_valid)     begin o.n_link++; o.ldata = bif.link_data; end
            if (bif.misalign_exc)   o.n_mis++;
            if (bif.illegal_exc)    o.n_ill++;
            if (bif.flush)          o.n_flush++;
            if (bif.br_ready)       begin o.ready_k = k; break; end
        end
    endtask

    task automatic bump(input vec_t e);
        if (exp_res < CMAX) exp_res++;
        if (e.red && exp_tk < CMAX) exp_tk++;
    endtask

    task automatic compare(input string tag, input vec_t e, input obs_t o);
        chk({tag, ".done_at"}, o.done_k, 2);
        chk({tag, ".done_cnt"}, o.n_done, 1);
        chk({tag, ".redirect"}, o.n_red, e.red);
        if (e.red) begin
            chk({tag, ".redirect_at"}, o.redir_k, 2);
            chk({tag, ".redirect_pc"}, o.rpc, e.rpc);
        end
        chk({tag, ".link"}, o.n_link, e.lnk);
        if (e.lnk) chk({tag, ".link_data"}, o.ldata, e.ldata);
        chk({tag, ".misalign"}, o.n_mis, e.mis);
        chk({tag, ".illegal"}, o.n_ill, e.ill);
        chk({tag, ".flush_cycles"}, o.n_flush, e.red ? FC : 0);
        chk({tag, ".ready_at"}, o.ready_k, e.red ? 2 + FC : 2);
        chk({tag, ".resolved_count"}, bif.resolved_count, exp_res);
        chk({tag, ".taken_count"}, bif.taken_count, exp_tk);
    endtask

    // Entered on a falling edge with br_ready high; inputs are scrambled once accepted.
    task automatic run(input string tag, input vec_t e);
        obs_t o;
        drive(e);
        @(posedge clk); #1;
        bif.br_valid = 1'b0;
        bif.is_branch = 1'($urandom()); bif.is_jal = 1'($urandom()); bif.is_jalr = 1'($urandom());
        bif.func_3 = 3'($urandom()); bif.rs1_data = $urandom(); bif.rs2_data = $urandom();
        bif.pc = $urandom(); bif.imm = $urandom();
        observe(o);
        bump(e);
        compare(tag, e, o);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t        o;
        vec_t        v, e1, e2;
        logic [2:0]  flags;

        tbl[0]  = mk(1,0,0,3'd0, 32'h5,        32'h5,        32'h100,      32'h20,       1,32'h120, 0,32'h0,   0,0);
        tbl[1]  = mk(1,0,0,3'd4, 32'hFFFFFFFF, 32'h1,        32'h300,      32'h40,       1,32'h340, 0,32'h0,   0,0);
        tbl[2]  = mk(1,0,0,3'd6, 32'hFFFFFFFF, 32'h1,        32'h300,      32'h40,       0,32'h0,   0,32'h0,   0,0);
        tbl[3]  = mk(0,0,1,3'd0, 32'h1003,     32'h0,        32'h200,      32'h4,        0,32'h0,   0,32'h0,   1,0);
        tbl[4]  = mk(0,0,1,3'd0, 32'h1001,     32'h0,        32'h200,      32'h4,        1,32'h1004,1,32'h204, 0,0);
        tbl[5]  = mk(1,0,0,3'd2, 32'h5,        32'h5,        32'h100,      32'h20,       0,32'h0,   0,32'h0,   0,1);
        tbl[6]  = mk(1,0,0,3'd3, 32'h1,        32'h2,        32'h100,      32'h20,       0,32'h0,   0,32'h0,   0,1);
        tbl[7]  = mk(1,0,0,3'd1, 32'h5,        32'h5,        32'h100,      32'h20,       0,32'h0,   0,32'h0,   0,0);
        tbl[8]  = mk(1,0,0,3'd5, 32'h1,        32'hFFFFFFFF, 32'h400,      32'hFFFFFFF0, 1,32'h3F0, 0,32'h0,   0,0);
        tbl[9]  = mk(1,0,0,3'd7, 32'h1,        32'hFFFFFFFF, 32'h400,      32'hFFFFFFF0, 0,32'h0,   0,32'h0,   0,0);
        tbl[10] = mk(0,1,0,3'd0, 32'h0,        32'h0,        32'h500,      32'h100,      1,32'h600, 1,32'h504, 0,0);
        tbl[11] = mk(0,1,0,3'd0, 32'h0,        32'h0,        32'h500,      32'h2,        0,32'h0,   0,32'h0,   1,0);
        tbl[12] = mk(0,0,0,3'd0, 32'h3,        32'h3,        32'h100,      32'h20,       0,32'h0,   0,32'h0,   0,0);
        tbl[13] = mk(1,1,1,3'd2, 32'h2000,     32'h0,        32'h10,       32'h8,        1,32'h2008,1,32'h14,  0,0);
        tbl[14] = mk(1,1,0,3'd1, 32'h7,        32'h7,        32'h40,       32'h80,       1,32'hC0,  1,32'h44,  0,0);
        tbl[15] = mk(1,0,0,3'd0, 32'h9,        32'h9,        32'hFFFFFFF0, 32'h20,       1,32'h10,  0,32'h0,   0,0);
        tbl[16] = mk(1,0,0,3'd6, 32'h1,        32'h2,        32'h100,      32'h6,        0,32'h0,   0,32'h0,   1,0);

        rst_n = 1'b0;
        bif.br_valid = 1'b0; bif.is_branch = 1'b0; bif.is_jal = 1'b0; bif.is_jalr = 1'b0;
        bif.func_3 = 3'd0; bif.rs1_data = '0; bif.rs2_data = '0; bif.pc = '0; bif.imm = '0;
        repeat (2) @(negedge clk);
        chk("rst.br_ready", bif.br_ready, 1);
        chk("rst.redirect_valid", bif.redirect_valid, 0);
        chk("rst.link_valid", bif.link_valid, 0);
        chk("rst.flush", bif.flush, 0);
        chk("rst.done", bif.done, 0);
        chk("rst.misalign", bif.misalign_exc, 0);
        chk("rst.illegal", bif.illegal_exc, 0);
        chk("rst.taken_count", bif.taken_count, 0);
        chk("rst.resolved_count", bif.resolved_count, 0);
        chk("rst.redirect_pc", bif.redirect_pc, 0);
        chk("rst.link_data", bif.link_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready_after_release", bif.br_ready, 1);

        for (int i = 0; i < NTBL; i++) run($sformatf("vec%0d", i), tbl[i]);

        // br_valid stays high with a different op while the first one redirects and flushes.
        e1 = mk(1,0,0,3'd0, 32'hA, 32'hA, 32'h900, 32'h40, 1,32'h940, 0,32'h0,  0,0);
        e2 = mk(0,1,0,3'd0, 32'h0, 32'h0, 32'h800, 32'h10, 1,32'h810, 1,32'h804,0,0);
        drive(e1);
        @(posedge clk); #1;
        drive(e2);
        observe(o);
        bump(e1);
        compare("hold.op1", e1, o);
        @(posedge clk); #1;
        bif.br_valid = 1'b0;
        observe(o);
        bump(e2);
        compare("hold.op2", e2, o);

        // Reset landing on the REDIRECT cycle.
        drive(tbl[0]);
        @(posedge clk); #1;
        bif.br_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid.redirect_before", bif.redirect_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.redirect_valid", bif.redirect_valid, 0);
        chk("rstmid.flush", bif.flush, 0);
        chk("rstmid.done", bif.done, 0);
        chk("rstmid.link_valid", bif.link_valid, 0);
        chk("rstmid.br_ready", bif.br_ready, 1);
        chk("rstmid.redirect_pc", bif.redirect_pc, 0);
        chk("rstmid.taken_count", bif.taken_count, 0);
        chk("rstmid.resolved_count", bif.resolved_count, 0);
        exp_res = 0;
        exp_tk  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstmid.post%0d.redirect", k), bif.redirect_valid, 0);
            chk($sformatf("rstmid.post%0d.flush", k), bif.flush, 0);
            chk($sformatf("rstmid.post%0d.br_ready", k), bif.br_ready, 1);
        end

        for (int i = 0; i < 120; i++) begin
            flags = 3'($urandom_range(0, 7));
            v.br = flags[0]; v.jal = flags[1]; v.jalr = flags[2];
            v.f3  = 3'($urandom());
            v.rs1 = $urandom();
            if ($urandom_range(0, 3) != 0) v.rs1 = v.rs1 & 32'hFFFF_FFFC;
            v.rs2 = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom();
            v.pc  = $urandom() & 32'hFFFF_FFFC;
            v.imm = $urandom();
            if ($urandom_range(0, 3) != 0) v.imm = v.imm & 32'hFFFF_FFFC;
            v = model(v);
            run($sformatf("rnd%0d", i), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
